// File: rtl/pll_lock_controller.sv
// Power-up sequencer for one PLL: start-up delay, lock wait with timeout, lock qualification, bounded retries.
// All outputs registered and reflect the new state on the transition edge; PLL_LOCK sees 2 cycles of sync latency.
module pll_lock_controller #(
  parameter int STARTUP_DELAY = 16,
  parameter int LOCK_TIMEOUT  = 1024,
  parameter int LOCK_STABLE   = 64,
  parameter int RETRY_GAP     = 32,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic       PLL_LOCK,
  output logic       PLL_EN,
  output logic       CLK_GATE_EN,
  output logic       READY,
  output logic       FAIL,
  output logic [3:0] RETRY_COUNT,
  output logic [2:0] STATE
);

  localparam int TMAX0 = (STARTUP_DELAY > RETRY_GAP) ? STARTUP_DELAY : RETRY_GAP;
  localparam int TMAX  = (TMAX0 > LOCK_TIMEOUT) ? TMAX0 : LOCK_TIMEOUT;
  localparam int TW    = $clog2(TMAX + 1);
  localparam int SW    = $clog2(LOCK_STABLE + 1);

  localparam logic [TW-1:0] SD_LAST = TW'(STARTUP_DELAY - 1);
  localparam logic [TW-1:0] LT_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] LT_SAT  = TW'(LOCK_TIMEOUT);
  localparam logic [TW-1:0] RG_LAST = TW'(RETRY_GAP - 1);
  localparam logic [SW-1:0] LS_LAST = SW'(LOCK_STABLE - 1);
  localparam logic [3:0]    MAX_RC  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PWRUP     = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_STABLE    = 3'd3,
    S_RUN       = 3'd4,
    S_RETRY_OFF = 3'd5,
    S_FAILED    = 3'd6
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic [SW-1:0] scnt, scnt_nxt;
  logic [3:0]    rc, rc_nxt;
  logic          retry_req;
  logic          lk_m, lk_s;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lk_m <= 1'b0;
      lk_s <= 1'b0;
    end else begin
      lk_m <= PLL_LOCK;
      lk_s <= lk_m;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= S_IDLE;
      tcnt  <= '0;
      scnt  <= '0;
      rc    <= '0;
    end else begin
      state <= state_nxt;
      tcnt  <= tcnt_nxt;
      scnt  <= scnt_nxt;
      rc    <= rc_nxt;
    end
  end

  // tcnt is shared by the three timed states; it is left frozen in STABLE so a
  // lock glitch resumes the original timeout budget instead of restarting it.
  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt;
    scnt_nxt  = scnt;
    rc_nxt    = rc;
    retry_req = 1'b0;
    if (!START) begin
      state_nxt = S_IDLE;
      tcnt_nxt  = '0;
      scnt_nxt  = '0;
      rc_nxt    = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_nxt = S_PWRUP;
          tcnt_nxt  = '0;
        end
        S_PWRUP: begin
          if (tcnt >= SD_LAST) begin
            state_nxt = S_WAIT_LOCK;
            tcnt_nxt  = '0;
          end else begin
            tcnt_nxt = tcnt + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (tcnt < LT_SAT) tcnt_nxt = tcnt + 1'b1;
          if (lk_s) begin
            state_nxt = S_STABLE;
            scnt_nxt  = '0;
          end else if (tcnt >= LT_LAST) begin
            retry_req = 1'b1;
          end
        end
        S_STABLE: begin
          if (!lk_s) begin
            state_nxt = S_WAIT_LOCK;
          end else if (scnt >= LS_LAST) begin
            state_nxt = S_RUN;
          end else begin
            scnt_nxt = scnt + 1'b1;
          end
        end
        S_RUN: begin
          if (!lk_s) retry_req = 1'b1;
        end
        S_RETRY_OFF: begin
          if (tcnt >= RG_LAST) begin
            state_nxt = S_WAIT_LOCK;
            tcnt_nxt  = '0;
          end else begin
            tcnt_nxt = tcnt + 1'b1;
          end
        end
        S_FAILED: state_nxt = S_FAILED;
        default:  state_nxt = S_IDLE;
      endcase

      if (retry_req) begin
        tcnt_nxt = '0;
        scnt_nxt = '0;
        if (rc < MAX_RC) begin
          state_nxt = S_RETRY_OFF;
          rc_nxt    = rc + 4'd1;
        end else begin
          state_nxt = S_FAILED;
        end
      end
    end
  end

  // Outputs decode the next state so they switch on the transition edge itself.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      PLL_EN      <= 1'b0;
      CLK_GATE_EN <= 1'b0;
      READY       <= 1'b0;
      FAIL        <= 1'b0;
    end else begin
      PLL_EN      <= (state_nxt == S_WAIT_LOCK) || (state_nxt == S_STABLE) ||
                     (state_nxt == S_RUN);
      CLK_GATE_EN <= (state_nxt == S_RUN);
      READY       <= (state_nxt == S_RUN);
      FAIL        <= (state_nxt == S_FAILED);
    end
  end

  assign RETRY_COUNT = rc;
  assign STATE       = state;

endmodule

// File: tb/tb_pll_lock_controller.sv
// Bench for pll_lock_controller: expected outputs are queued per cycle as stimulus is driven and compared at negedge.
module tb_pll_lock_controller;

  localparam int S_IDLE = 0, S_PWRUP = 1, S_WAIT = 2, S_STABLE = 3;
  localparam int S_RUN = 4, S_RETRY = 5, S_FAILED = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       pll_lock = 1'b0;
  logic       pll_en, clk_gate_en, ready, fail;
  logic [3:0] retry_count;
  logic [2:0] state;
  logic [10:0] obs;

  typedef struct {
    int          cyc;
    string       tag;
    logic [10:0] exp;
  } sb_ent_t;

  sb_ent_t sb[$];
  sb_ent_t mon_e;
  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  pll_lock_controller #(
    .STARTUP_DELAY(4),
    .LOCK_TIMEOUT (20),
    .LOCK_STABLE  (8),
    .RETRY_GAP    (6),
    .MAX_RETRIES  (2)
  ) dut (
    .CLK        (clk),
    .RESET      (rst),
    .START      (start),
    .PLL_LOCK   (pll_lock),
    .PLL_EN     (pll_en),
    .CLK_GATE_EN(clk_gate_en),
    .READY      (ready),
    .FAIL       (fail),
    .RETRY_COUNT(retry_count),
    .STATE      (state)
  );

  assign obs = {pll_en, clk_gate_en, ready, fail, retry_count, state};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [10:0] exp_out(input int st, input int rc);
    logic en, run, fl;
    en  = (st == S_WAIT) || (st == S_STABLE) || (st == S_RUN);
    run = (st == S_RUN);
    fl  = (st == S_FAILED);
    return {en, run, run, fl, 4'(rc), 3'(st)};
  endfunction

  task automatic chk(input string tag, input logic [10:0] got, input logic [10:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_at(input int c, input string tag, input int st, input int rc);
    sb_ent_t e;
    int i;
    e.cyc = c;
    e.tag = tag;
    e.exp = exp_out(st, rc);
    i = sb.size();
    while (i > 0 && sb[i-1].cyc > c) i--;
    sb.insert(i, e);
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      chk(mon_e.tag, obs, mon_e.exp);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, f, d, p, g, e1, h, e, k, e6;
    #1 rst = 1'b1;
    #12 chk("reset_state", obs, 11'd0);
    @(negedge clk);
    rst = 1'b0;

    // nominal bring-up
    c0 = cyc;
    expect_at(c0 + 1,  "nom_pwrup_first", S_PWRUP, 0);
    expect_at(c0 + 4,  "nom_pwrup_last",  S_PWRUP, 0);
    expect_at(c0 + 5,  "nom_pll_en",      S_WAIT, 0);
    expect_at(c0 + 17, "nom_sync_delay",  S_WAIT, 0);
    expect_at(c0 + 18, "nom_stable",      S_STABLE, 0);
    expect_at(c0 + 25, "nom_pre_ready",   S_STABLE, 0);
    expect_at(c0 + 26, "nom_ready",       S_RUN, 0);
    start = 1'b1;
    goto(c0 + 15);
    pll_lock = 1'b1;

    // lock loss in RUN, retry gap, relock
    f = c0 + 30;
    goto(f);
    expect_at(f + 2,  "loss_still_run", S_RUN, 0);
    expect_at(f + 3,  "loss_gate_off",  S_RETRY, 1);
    expect_at(f + 8,  "loss_gap_last",  S_RETRY, 1);
    expect_at(f + 9,  "loss_reenable",  S_WAIT, 1);
    expect_at(f + 15, "relock_stable",  S_STABLE, 1);
    expect_at(f + 22, "relock_pre",     S_STABLE, 1);
    expect_at(f + 23, "relock_ready",   S_RUN, 1);
    pll_lock = 1'b0;
    goto(f + 12);
    pll_lock = 1'b1;

    // START dropped from RUN, then from STABLE
    d = f + 26;
    goto(d);
    expect_at(d + 1,  "stop_run_idle",    S_IDLE, 0);
    expect_at(d + 7,  "restart_wait",     S_WAIT, 0);
    expect_at(d + 8,  "restart_stable",   S_STABLE, 0);
    expect_at(d + 10, "stable_before_stop", S_STABLE, 0);
    expect_at(d + 11, "stop_stable_idle", S_IDLE, 0);
    start = 1'b0;
    goto(d + 2);
    start = 1'b1;
    goto(d + 10);
    start = 1'b0;
    goto(d + 11);
    pll_lock = 1'b0;

    // one-cycle lock glitch during qualification
    goto(d + 12);
    p = d + 18;
    expect_at(p + 2,  "glitch_wait",        S_WAIT, 0);
    expect_at(p + 3,  "glitch_stable",      S_STABLE, 0);
    expect_at(p + 8,  "glitch_cnt5",        S_STABLE, 0);
    expect_at(p + 9,  "glitch_back_wait",   S_WAIT, 0);
    expect_at(p + 10, "glitch_restable",    S_STABLE, 0);
    expect_at(p + 17, "glitch_pre_ready",   S_STABLE, 0);
    expect_at(p + 18, "glitch_ready",       S_RUN, 0);
    expect_at(p + 20, "glitch_run_hold",    S_RUN, 0);
    start = 1'b1;
    goto(p);
    pll_lock = 1'b1;
    goto(p + 6);
    pll_lock = 1'b0;
    goto(p + 7);
    pll_lock = 1'b1;

    // asynchronous reset while running
    goto(p + 20);
    #2;
    rst = 1'b1;
    start = 1'b0;
    pll_lock = 1'b0;
    #1 chk("rst_async_run", obs, 11'd0);
    @(negedge clk);
    rst = 1'b0;

    // never locks: three windows then FAILED
    g = cyc;
    e1 = g + 5;
    expect_at(e1 - 1,  "nolock_pwrup",   S_PWRUP, 0);
    expect_at(e1,      "nolock_win1",    S_WAIT, 0);
    expect_at(e1 + 19, "nolock_win1_end", S_WAIT, 0);
    expect_at(e1 + 20, "nolock_to1",     S_RETRY, 1);
    expect_at(e1 + 25, "nolock_gap1_end", S_RETRY, 1);
    expect_at(e1 + 26, "nolock_win2",    S_WAIT, 1);
    expect_at(e1 + 45, "nolock_win2_end", S_WAIT, 1);
    expect_at(e1 + 46, "nolock_to2",     S_RETRY, 2);
    expect_at(e1 + 51, "nolock_gap2_end", S_RETRY, 2);
    expect_at(e1 + 52, "nolock_win3",    S_WAIT, 2);
    expect_at(e1 + 71, "nolock_win3_end", S_WAIT, 2);
    expect_at(e1 + 72, "nolock_failed",  S_FAILED, 2);
    expect_at(e1 + 82, "nolock_sticky",  S_FAILED, 2);
    expect_at(e1 + 84, "nolock_clear",   S_IDLE, 0);
    start = 1'b1;
    goto(e1 + 83);
    start = 1'b0;

    // START dropped in RETRY_OFF
    h = e1 + 86;
    goto(h);
    e = h + 5;
    expect_at(e + 19, "roff_wait_end", S_WAIT, 0);
    expect_at(e + 20, "roff_enter",    S_RETRY, 1);
    expect_at(e + 22, "roff_hold",     S_RETRY, 1);
    expect_at(e + 23, "roff_stop_idle", S_IDLE, 0);
    start = 1'b1;
    goto(e + 22);
    start = 1'b0;

    // lock first seen on the timeout cycle wins
    k = e + 25;
    goto(k);
    e6 = k + 5;
    expect_at(e6,      "tie_wait",       S_WAIT, 0);
    expect_at(e6 + 19, "tie_wait_end",   S_WAIT, 0);
    expect_at(e6 + 20, "tie_lock_wins",  S_STABLE, 0);
    expect_at(e6 + 27, "tie_pre_ready",  S_STABLE, 0);
    expect_at(e6 + 28, "tie_ready",      S_RUN, 0);
    start = 1'b1;
    goto(e6 + 17);
    pll_lock = 1'b1;
    goto(e6 + 32);

    chk("sb_drain", 11'(sb.size()), 11'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
